// File: rtl/rng_pkg.sv
// Shared types and constants for the xorshift128 stream generator.
package rng_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  // xorshift128 shift amounts
  localparam int unsigned XS_SHIFT_A = 11;
  localparam int unsigned XS_SHIFT_B = 19;
  localparam int unsigned XS_SHIFT_C = 8;

  // Substitute state used when the incoming seed is all zeros
  // (an all-zero xorshift state never leaves zero).
  localparam word_t SEED_X_DEF = 32'd123456789;
  localparam word_t SEED_Y_DEF = 32'd362436069;
  localparam word_t SEED_Z_DEF = 32'd521288629;
  localparam word_t SEED_W_DEF = 32'd88675123;

endpackage

// File: rtl/xs128_step.sv
// One xorshift128 step as pure combinational logic; shared by the warm-up
// path and intended for reuse by a multi-step jump stage.
module xs128_step
  import rng_pkg::*;
(
  input  word_t x_i,
  input  word_t y_i,
  input  word_t z_i,
  input  word_t w_i,
  output word_t x_o,
  output word_t y_o,
  output word_t z_o,
  output word_t w_o
);

  word_t t;

  // Rotate the word window and fold the mixed x into the new w
  always_comb begin
    t   = x_i ^ (x_i << XS_SHIFT_A);
    x_o = y_i;
    y_o = z_i;
    z_o = w_i;
    w_o = w_i ^ (w_i >> XS_SHIFT_B) ^ t ^ (t >> XS_SHIFT_C);
  end

endmodule

// File: rtl/xs128_stream.sv
// xorshift128 word stream: loads an expanded seed, discards WARMUP outputs,
// then delivers one 32-bit word per valid/ready handshake.
module xs128_stream
  import rng_pkg::*;
#(
  parameter int unsigned WARMUP = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [31:0]      seed_words [3:0],
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [31:0]      rnd_data,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  // Wide enough to hold WARMUP itself, never zero bits wide
  localparam int unsigned WU_W = $clog2(WARMUP + 2);

  state_t           state_q, state_d;
  word_t            x_q, y_q, z_q, w_q;
  word_t            x_d, y_d, z_d, w_d;
  word_t            x_nx, y_nx, z_nx, w_nx;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             step_en;
  logic             seed_fire;
  logic             seed_zero;

  xs128_step u_step (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .w_i (w_q),
    .x_o (x_nx),
    .y_o (y_nx),
    .z_o (z_nx),
    .w_o (w_nx)
  );

  assign seed_zero  = ({seed_words[3], seed_words[2], seed_words[1], seed_words[0]} == '0);
  assign rnd_data   = w_q;
  assign word_count = wc_q;

  // Next-state, handshake outputs and generator update; a seed load
  // overrides any step requested in the same cycle
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    w_d        = w_q;
    wu_d       = wu_q;
    wc_d       = wc_q;
    seed_ready = 1'b0;
    rnd_valid  = 1'b0;
    busy       = 1'b0;
    step_en    = 1'b0;
    seed_fire  = 1'b0;

    case (state_q)
      rng_pkg::IDLE: begin
        seed_ready = 1'b1;
      end
      rng_pkg::WARMUP: begin
        busy    = 1'b1;
        step_en = 1'b1;
        wu_d    = wu_q - WU_W'(1);
        // The step taken with the counter at 1 is the last discarded one
        if (wu_q <= WU_W'(1)) begin
          state_d = rng_pkg::RUN;
        end
      end
      rng_pkg::RUN: begin
        seed_ready = 1'b1;
        rnd_valid  = 1'b1;
        if (rnd_ready) begin
          step_en = 1'b1;
          wc_d    = wc_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = rng_pkg::IDLE;
      end
    endcase

    if (step_en) begin
      x_d = x_nx;
      y_d = y_nx;
      z_d = z_nx;
      w_d = w_nx;
    end

    seed_fire = seed_valid && seed_ready;
    if (seed_fire) begin
      if (seed_zero) begin
        x_d = SEED_X_DEF;
        y_d = SEED_Y_DEF;
        z_d = SEED_Z_DEF;
        w_d = SEED_W_DEF;
      end else begin
        x_d = seed_words[0];
        y_d = seed_words[1];
        z_d = seed_words[2];
        w_d = seed_words[3];
      end
      wc_d    = '0;
      wu_d    = WU_W'(WARMUP);
      state_d = (WARMUP == 0) ? rng_pkg::RUN : rng_pkg::WARMUP;
    end
  end

  // State, generator and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= rng_pkg::IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      w_q     <= '0;
      wu_q    <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      w_q     <= w_d;
      wu_q    <= wu_d;
      wc_q    <= wc_d;
    end
  end

endmodule

// File: tb/tb_xs128_stream.sv
// Directed bench for xs128_stream with a queue scoreboard of expected words.
module tb_xs128_stream;
  import rng_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance with WARMUP = 0
  logic        sv0, sr0, rv0, rr0, busy0;
  logic [31:0] sw0 [3:0];
  logic [31:0] rd0, wc0;

  // Instance with WARMUP = 16
  logic        sv16, sr16, rv16, rr16, busy16;
  logic [31:0] sw16 [3:0];
  logic [31:0] rd16, wc16;

  xs128_stream #(.WARMUP(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv0), .seed_ready(sr0),
    .seed_words(sw0), .rnd_valid(rv0), .rnd_ready(rr0), .rnd_data(rd0),
    .busy(busy0), .word_count(wc0)
  );

  xs128_stream #(.WARMUP(16), .CNT_W(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv16), .seed_ready(sr16),
    .seed_words(sw16), .rnd_valid(rv16), .rnd_ready(rr16), .rnd_data(rd16),
    .busy(busy16), .word_count(wc16)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_wc;
  logic [31:0] prev_data, prev_wc;

  // Reference xorshift128 step on {w,z,y,x}
  function automatic logic [127:0] ref_step(input logic [127:0] s);
    logic [31:0] a, b, c, d, t, dn;
    a  = s[31:0];
    b  = s[63:32];
    c  = s[95:64];
    d  = s[127:96];
    t  = a ^ (a << 11);
    dn = d ^ (d >> 19) ^ t ^ (t >> 8);
    return {dn, d, c, b};
  endfunction

  // Push n expected words for a seed after skipping 'skip' steps
  task automatic push_stream(input logic [31:0] sx, sy, sz, sw, input int skip, input int n);
    logic [127:0] s;
    s = {sw, sz, sy, sx};
    if (s == '0) s = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};
    repeat (skip) s = ref_step(s);
    repeat (n) begin
      exp_q.push_back(s[127:96]);
      s = ref_step(s);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seed16(input logic [31:0] x, y, z, w);
    sw16[0] = x; sw16[1] = y; sw16[2] = z; sw16[3] = w;
  endtask

  // One cycle on dut16: scoreboard any handshake, then advance
  task automatic cycle16(input logic rdy);
    rr16 = rdy;
    if (rv16 && rdy) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("rnd_data", rd16, exp_q.pop_front());
      exp_wc++;
      $display("word %0d data %0d", exp_wc, rd16);
    end
    tick();
  endtask

  // Count cycles after an accept until rnd_valid rises (cycle 1 = first after accept)
  task automatic wait_valid16(output int n);
    n = 1;
    while (!rv16 && n < 40) begin
      tick();
      n++;
    end
  endtask

  logic [31:0]  s1_exp [4];
  logic [127:0] s_tmp;
  int           n;
  logic [3:0]   bp_pat;

  initial begin
    s1_exp[0] = 32'd88675123;
    s1_exp[1] = 32'd3701687786;
    s1_exp[2] = 32'd458299110;
    s1_exp[3] = 32'd2500872618;

    rst_n = 1'b0;
    sv0 = 1'b0; rr0 = 1'b0; sv16 = 1'b0; rr16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw0[i]  = '0;
      sw16[i] = '0;
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", rv16, 0);
    check("rst_ready", sr16, 1);
    check("rst_busy", busy16, 0);
    check("rst_count", wc16, 0);
    check("rst_data", rd16, 0);
    check("rst_ready0", sr0, 1);

    // Scenario 1: zero seed, WARMUP=0, ready held
    sv0 = 1'b1;
    rr0 = 1'b1;
    tick();
    sv0 = 1'b0;
    check("s1_valid", rv0, 1);
    for (int i = 0; i < 4; i++) begin
      check("s1_data", rd0, s1_exp[i]);
      $display("s1 word %0d data %0d", i, rd0);
      tick();
    end
    check("s1_count", wc0, 4);

    // WARMUP=0 reseed in RUN: next word is seed w, count cleared
    sw0[0] = 32'd1; sw0[1] = 32'd2; sw0[2] = 32'd3; sw0[3] = 32'hDEADBEEF;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    check("s1r_data", rd0, 32'hDEADBEEF);
    check("s1r_count", wc0, 0);
    check("s1r_valid", rv0, 1);
    s_tmp = ref_step({32'hDEADBEEF, 32'd3, 32'd2, 32'd1});
    tick();
    check("s1r_next", rd0, s_tmp[127:96]);
    check("s1r_count1", wc0, 1);

    // Scenario 2 + 5: zero seed, WARMUP=16, a seed pulse during warm-up is ignored
    set_seed16(0, 0, 0, 0);
    sv16 = 1'b1;
    rr16 = 1'b1;
    check("s2_seed_ready", sr16, 1);
    exp_q.delete();
    push_stream(0, 0, 0, 0, 16, 12);
    exp_wc = 0;
    tick();
    sv16 = 1'b0;
    n = 1;
    while (!rv16 && n < 40) begin
      if (n == 2) check("s2_busy", busy16, 1);
      if (n == 3) begin
        check("s5_seed_ready", sr16, 0);
        set_seed16(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        sv16 = 1'b1;
      end else begin
        sv16 = 1'b0;
      end
      tick();
      n++;
    end
    sv16 = 1'b0;
    check("s2_latency", n, 17);
    check("s2_run_busy", busy16, 0);
    for (int i = 0; i < 4; i++) cycle16(1'b1);
    check("s2_count", wc16, exp_wc);

    // Scenario 3: backpressure 1,0,0,1 then 1,0,1
    bp_pat = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      prev_data = rd16;
      prev_wc   = wc16;
      cycle16(bp_pat[i]);
      if (!bp_pat[i]) begin
        check("s3_hold_data", rd16, prev_data);
        check("s3_hold_count", wc16, prev_wc);
      end
    end
    cycle16(1'b1);
    prev_data = rd16;
    cycle16(1'b0);
    check("s3_hold_data2", rd16, prev_data);
    cycle16(1'b1);
    check("s3_count", wc16, exp_wc);

    // Scenario 4: reseed in RUN with a same-cycle handshake
    set_seed16(32'hCAFEF00D, 32'h0BADBEEF, 32'h13579BDF, 32'h2468ACE0);
    sv16 = 1'b1;
    cycle16(1'b1);
    sv16 = 1'b0;
    check("s4_count_clr", wc16, 0);
    check("s4_valid_drop", rv16, 0);
    check("s4_busy", busy16, 1);
    exp_q.delete();
    push_stream(32'hCAFEF00D, 32'h0BADBEEF, 32'h13579BDF, 32'h2468ACE0, 16, 6);
    exp_wc = 0;
    wait_valid16(n);
    check("s4_latency", n, 17);
    for (int i = 0; i < 5; i++) cycle16(1'b1);
    check("s4_count", wc16, 5);

    // Scenario 6: one-cycle reset mid-RUN, then a clean restart
    rr16  = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s6_valid", rv16, 0);
    check("s6_count", wc16, 0);
    check("s6_ready", sr16, 1);
    check("s6_busy", busy16, 0);
    check("s6_data", rd16, 0);
    set_seed16(32'd5, 32'd6, 32'd7, 32'd8);
    sv16 = 1'b1;
    exp_q.delete();
    push_stream(32'd5, 32'd6, 32'd7, 32'd8, 16, 3);
    exp_wc = 0;
    tick();
    sv16 = 1'b0;
    wait_valid16(n);
    check("s6_latency", n, 17);
    for (int i = 0; i < 3; i++) cycle16(1'b1);
    check("s6_count_end", wc16, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
